// File: rtl/heuristic_selector_stream.sv
// heuristic_selector_stream
//   Streaming WalkSAT flip selector. Collects a frame of up to NSAT candidate
//   flips (label + break value), then picks one per frame using a greedy
//   minimum-break choice, an optional zero-break override and a probabilistic
//   random walk driven by a 32-bit random word (from lfsr_prng).
//
//   Optional feature macro: HS_ZERO_OVERRIDE_EN
//     defined   -> a frame containing a zero-break candidate always selects the
//                  earliest such candidate, never the random walk.
//     undefined -> the random walk applies regardless of zero-break candidates.
//
//   Ports:
//     clk                 sole clock, rising edge
//     reset               asynchronous active-low reset
//     in_valid_i/in_ready_o     candidate beat handshake
//     current_flip_i      candidate label
//     break_value_i       candidate break value
//     last_i              final beat of the frame
//     random_i            random word, sampled with the frame-end beat
//     out_valid_o/out_ready_i   decision handshake
//     selected_flip_o     label of the chosen candidate
//     random_selection_o  decision came from the random walk
//     min_break_o         minimum break value of the frame
//     overflow_o          frame force-terminated at NSAT beats
module heuristic_selector_stream #(
   parameter int          NSAT                          = 7,
   parameter int          NSAT_BITS                     = 3,
   parameter int          MAX_CLAUSES_PER_VARIABLE_BITS = 5,
   parameter logic [31:0] P                             = 32'd268435455
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     in_valid_i,
   output logic                                     in_ready_o,
   input  logic [NSAT_BITS-1:0]                     current_flip_i,
   input  logic [MAX_CLAUSES_PER_VARIABLE_BITS-1:0] break_value_i,
   input  logic                                     last_i,
   input  logic [31:0]                              random_i,
   output logic                                     out_valid_o,
   input  logic                                     out_ready_i,
   output logic [NSAT_BITS-1:0]                     selected_flip_o,
   output logic                                     random_selection_o,
   output logic [MAX_CLAUSES_PER_VARIABLE_BITS-1:0] min_break_o,
   output logic                                     overflow_o
);

   localparam int CW = NSAT_BITS + 1;
   localparam int BW = MAX_CLAUSES_PER_VARIABLE_BITS;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DECIDE = 2'd1,
      OUT    = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_next_s;
   logic                  in_ready_r;
   logic [CW-1:0]         cnt_r;
   logic [NSAT_BITS-1:0]  slot_r [NSAT];
   logic [NSAT_BITS-1:0]  best_label_r;
   logic [BW-1:0]         best_break_r;
   logic                  zero_seen_r;
   logic                  overflow_r;
   logic [31:0]           rnd_r;
   logic                  out_valid_r;
   logic [NSAT_BITS-1:0]  sel_r;
   logic                  rs_r;
   logic [BW-1:0]         min_break_r;

   logic                  accept_s;
   logic                  frame_end_s;
   logic                  handshake_s;
   logic                  walk_s;
   logic [CW-1:0]         walk_idx_s;
   logic [NSAT_BITS-1:0]  walk_label_s;
   logic [NSAT_BITS-1:0]  dec_label_s;
   logic                  dec_random_s;

   assign accept_s    = in_valid_i & in_ready_r & (state_r == ACCUM);
   // The NSAT-th beat (cnt == NSAT-1 before increment) closes the frame even without last_i.
   assign frame_end_s = accept_s & (last_i | (cnt_r == CW'(NSAT - 1)));
   assign handshake_s = out_valid_r & out_ready_i;

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ACCUM: begin
            if (frame_end_s) state_next_s = DECIDE;
            else             state_next_s = ACCUM;
         end
         DECIDE: state_next_s = OUT;
         OUT: begin
            if (out_ready_i) state_next_s = ACCUM;
            else             state_next_s = OUT;
         end
         default: state_next_s = ACCUM;
      endcase
   end

   // Decision logic: random-walk index scales rnd[15:0] by cnt so it is always < cnt
   always_comb begin
      walk_s       = (rnd_r < P);
      walk_idx_s   = CW'(({{CW{1'b0}}, rnd_r[15:0]} * {16'd0, cnt_r}) >> 5'd16);
      walk_label_s = slot_r[0];
      for (int i = 0; i < NSAT; i++) begin
         if (walk_idx_s == CW'(i)) walk_label_s = slot_r[i];
         else                      walk_label_s = walk_label_s;
      end
      if (walk_s) begin
         dec_label_s  = walk_label_s;
         dec_random_s = 1'b1;
      end else begin
         dec_label_s  = best_label_r;
         dec_random_s = 1'b0;
      end
`ifdef HS_ZERO_OVERRIDE_EN
      // Strict-less-than tracking makes best_label the earliest zero when one exists.
      if (zero_seen_r) begin
         dec_label_s  = best_label_r;
         dec_random_s = 1'b0;
      end else begin
         dec_label_s  = dec_label_s;
         dec_random_s = dec_random_s;
      end
`endif
   end

   // State and input-ready registers; ready follows the state being entered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ACCUM;
         in_ready_r <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         in_ready_r <= (state_next_s == ACCUM);
      end
   end

   // Frame accumulation: slots, count, running minimum, zero flag, overflow, random latch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r        <= {CW{1'b0}};
         best_label_r <= {NSAT_BITS{1'b0}};
         best_break_r <= {BW{1'b0}};
         zero_seen_r  <= 1'b0;
         overflow_r   <= 1'b0;
         rnd_r        <= 32'd0;
         for (int i = 0; i < NSAT; i++) slot_r[i] <= {NSAT_BITS{1'b0}};
      end else if (handshake_s) begin
         cnt_r        <= {CW{1'b0}};
         best_label_r <= {NSAT_BITS{1'b0}};
         best_break_r <= {BW{1'b0}};
         zero_seen_r  <= 1'b0;
         overflow_r   <= 1'b0;
      end else if (accept_s) begin
         for (int i = 0; i < NSAT; i++) begin
            if (cnt_r == CW'(i)) slot_r[i] <= current_flip_i;
         end
         cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
         if ((cnt_r == {CW{1'b0}}) || (break_value_i < best_break_r)) begin
            best_label_r <= current_flip_i;
            best_break_r <= break_value_i;
         end
         if (break_value_i == {BW{1'b0}}) zero_seen_r <= 1'b1;
         if (frame_end_s) begin
            rnd_r      <= random_i;
            overflow_r <= ~last_i;
         end
      end
   end

   // Decision output registers, held until the consumer accepts
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_r <= 1'b0;
         sel_r       <= {NSAT_BITS{1'b0}};
         rs_r        <= 1'b0;
         min_break_r <= {BW{1'b0}};
      end else if (state_r == DECIDE) begin
         out_valid_r <= 1'b1;
         sel_r       <= dec_label_s;
         rs_r        <= dec_random_s;
         min_break_r <= best_break_r;
      end else if (handshake_s) begin
         out_valid_r <= 1'b0;
      end
   end

   assign in_ready_o         = in_ready_r;
   assign out_valid_o        = out_valid_r;
   assign selected_flip_o    = sel_r;
   assign random_selection_o = rs_r;
   assign min_break_o        = min_break_r;
   assign overflow_o         = overflow_r;

endmodule

// File: tb/tb_heuristic_selector_stream.sv
// Directed testbench for heuristic_selector_stream (default parameters).
module tb_heuristic_selector_stream;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  flip;
   logic [4:0]  brk;
   logic        last;
   logic [31:0] rnd;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  sel;
   logic        rsel;
   logic [4:0]  min_brk;
   logic        ovf;

   int vectors = 0;
   int miscompares = 0;

   heuristic_selector_stream dut (
      .clk                (clk),
      .reset              (rst_n),
      .in_valid_i         (in_valid),
      .in_ready_o         (in_ready),
      .current_flip_i     (flip),
      .break_value_i      (brk),
      .last_i             (last),
      .random_i           (rnd),
      .out_valid_o        (out_valid),
      .out_ready_i        (out_ready),
      .selected_flip_o    (sel),
      .random_selection_o (rsel),
      .min_break_o        (min_brk),
      .overflow_o         (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one beat and hold it until the edge that accepts it; returns #1 after that edge.
   task automatic beat(input logic [2:0] l, input logic [4:0] b, input logic lst, input logic [31:0] r);
      int t;
      t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1; flip = l; brk = b; last = lst; rnd = r;
      @(posedge clk); #1;
      in_valid = 1'b0; last = 1'b0;
   endtask

   // Called right after the frame-end beat: checks the two-edge latency and the decision, then handshakes.
   task automatic collect(input string tag, input logic [2:0] e_sel, input logic e_rs,
                          input logic [4:0] e_min, input logic e_ovf);
      check({tag, "_lat_k"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy_k"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check({tag, "_lat_k1"}, 32'(out_valid), 32'd1);
      check({tag, "_sel"}, 32'(sel), 32'(e_sel));
      check({tag, "_rsel"}, 32'(rsel), 32'(e_rs));
      check({tag, "_min"}, 32'(min_brk), 32'(e_min));
      check({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_done_ovf"}, 32'(ovf), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; flip = 3'd0; brk = 5'd0; last = 1'b0;
      rnd = 32'd0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_rsel", 32'(rsel), 32'd0);
      check("rst_min", 32'(min_brk), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_rst", 32'(in_ready), 32'd1);

      // Zero override: breaks 3,0,2, walk index (0x10*3)>>16 = 0
      beat(3'd0, 5'd3, 1'b0, 32'h0);
      beat(3'd1, 5'd0, 1'b0, 32'h0);
      beat(3'd2, 5'd2, 1'b1, 32'h0000_0010);
`ifdef HS_ZERO_OVERRIDE_EN
      collect("zero", 3'd1, 1'b0, 5'd0, 1'b0);
`else
      collect("zero", 3'd0, 1'b1, 5'd0, 1'b0);
`endif

      // Greedy: breaks 4,2,5, no walk
      beat(3'd0, 5'd4, 1'b0, 32'h0);
      beat(3'd1, 5'd2, 1'b0, 32'h0);
      beat(3'd2, 5'd5, 1'b1, 32'hFFFF_FFFF);
      collect("greedy", 3'd1, 1'b0, 5'd2, 1'b0);

      // Random walk: (0xFFFF*3)>>16 = 2
      beat(3'd0, 5'd4, 1'b0, 32'h0);
      beat(3'd1, 5'd2, 1'b0, 32'h0);
      beat(3'd2, 5'd5, 1'b1, 32'h0000_FFFF);
      collect("walk", 3'd2, 1'b1, 5'd2, 1'b0);

      // Ties: earliest candidate wins
      beat(3'd0, 5'd3, 1'b0, 32'h0);
      beat(3'd1, 5'd3, 1'b0, 32'h0);
      beat(3'd2, 5'd3, 1'b1, 32'h8000_0000);
      collect("tie_a", 3'd0, 1'b0, 5'd3, 1'b0);
      beat(3'd5, 5'd1, 1'b0, 32'h0);
      beat(3'd6, 5'd1, 1'b0, 32'h0);
      beat(3'd7, 5'd4, 1'b1, 32'h8000_0000);
      collect("tie_b", 3'd5, 1'b0, 5'd1, 1'b0);

      // Single-beat frame under walk: index must be 0
      beat(3'd4, 5'd7, 1'b1, 32'h0000_FFFF);
      collect("single", 3'd4, 1'b1, 5'd7, 1'b0);

      // Overflow: seven beats without last, breaks 9..3, then backpressure
      for (int i = 0; i < 7; i++)
         beat(3'(i), 5'(9 - i), 1'b0, 32'hFFFF_FFFF);
      check("ovf_ready_k", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("ovf_valid", 32'(out_valid), 32'd1);
      check("ovf_sel", 32'(sel), 32'd6);
      check("ovf_flag", 32'(ovf), 32'd1);
      check("ovf_min", 32'(min_brk), 32'd3);
      in_valid = 1'b1; flip = 3'd2; brk = 5'd0; last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_ready", 32'(in_ready), 32'd0);
         check("bp_sel", 32'(sel), 32'd6);
         check("bp_ovf", 32'(ovf), 32'd1);
         check("bp_min", 32'(min_brk), 32'd3);
      end
      in_valid = 1'b0; last = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("ovf_done_valid", 32'(out_valid), 32'd0);
      check("ovf_done_flag", 32'(ovf), 32'd0);

      // Reset mid-frame after two of three beats
      beat(3'd0, 5'd5, 1'b0, 32'h0);
      beat(3'd1, 5'd0, 1'b0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 32'(in_ready), 32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sel", 32'(sel), 32'd0);
      check("mid_rst_ovf", 32'(ovf), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      beat(3'd3, 5'd2, 1'b0, 32'h0);
      beat(3'd4, 5'd1, 1'b1, 32'hFFFF_FFFF);
      collect("fresh", 3'd4, 1'b0, 5'd1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
